// File: rtl/vga_pixel_pipe_if.sv
// vga_pixel_pipe_if: valid/ready pixel write port into the vga_pixel_pipe framebuffer.
// The write source (SPI receiver, drawing engine) is the master and the pixel pipe is the slave.
interface vga_pixel_pipe_if;
   logic       wr_valid;
   logic       wr_ready;
   logic [7:0] wr_x;
   logic [6:0] wr_y;
   logic [7:0] wr_data;

   modport master (output wr_valid, wr_x, wr_y, wr_data, input wr_ready);
   modport slave  (input wr_valid, wr_x, wr_y, wr_data, output wr_ready);
endinterface

// File: rtl/vga_pixel_pipe.sv
// vga_pixel_pipe: 160x120 8bpp framebuffer scaled onto the 640x480 raster, RRRGGGBB -> 24-bit RGB,
// with sync/blank delayed to match the two-cycle read path.
// Optional feature macro: VGA_PIXEL_PIPE_FB_CLEAR_EN (framebuffer clear state machine and clear input).
module vga_pixel_pipe #(
   parameter int FBW   = 160,
   parameter int FBH   = 120,
   parameter int SHIFT = 2,
   parameter int XW    = 10,
   parameter int YW    = 10
) (
   input  logic            vgaclk,
   input  logic            reset_b,
   input  logic [XW-1:0]   x,
   input  logic [YW-1:0]   y,
   input  logic            hsync_i,
   input  logic            vsync_i,
   input  logic            blank_b_i,
   input  logic            clear,
   vga_pixel_pipe_if.slave wr,
   output logic            hsync_o,
   output logic            vsync_o,
   output logic            blank_b_o,
   output logic [7:0]      r,
   output logic [7:0]      g,
   output logic [7:0]      b,
   output logic            wr_err
);

   localparam int DEPTH = FBW * FBH;
   localparam int AW    = 15;

   logic [AW-1:0] rd_addr;
   logic [AW-1:0] wr_addr;
   logic          wr_in_range;
   logic          wr_acc;
   logic          ready;
   logic          in_clear;
   logic          clr_we;
   logic [AW-1:0] clr_addr;

   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [7:0]    mem_wdata;
   logic [7:0]    mem [DEPTH];
   logic [7:0]    ram_q;

   logic [AW-1:0] s1_addr;
   logic          s1_hs, s1_vs, s1_blank_b, s1_show;
   logic          s2_hs, s2_vs, s2_blank_b, s2_show;

   // Raster position scaled down to a framebuffer address; don't-care while blanked.
   assign rd_addr     = AW'(y >> SHIFT) * AW'(FBW) + AW'(x >> SHIFT);
   assign wr_addr     = AW'(wr.wr_y) * AW'(FBW) + AW'(wr.wr_x);
   assign wr_in_range = (int'(wr.wr_x) < FBW) && (int'(wr.wr_y) < FBH);
   // A write coinciding with a reset edge is dropped.
   assign wr_acc      = wr.wr_valid & ready & reset_b;
   assign wr.wr_ready = ready;

   // Stage 1 registers the read address, stage 2 carries sync/blank alongside the RAM output.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge vgaclk) begin
      if (!reset_b) begin
         s1_addr    <= '0;
         s1_hs      <= 1'b1;
         s1_vs      <= 1'b1;
         s1_blank_b <= 1'b0;
         s1_show    <= 1'b0;
         s2_hs      <= 1'b1;
         s2_vs      <= 1'b1;
         s2_blank_b <= 1'b0;
         s2_show    <= 1'b0;
      end else begin
         s1_addr    <= rd_addr;
         s1_hs      <= hsync_i;
         s1_vs      <= vsync_i;
         s1_blank_b <= blank_b_i;
         s1_show    <= blank_b_i & ~in_clear;
         s2_hs      <= s1_hs;
         s2_vs      <= s1_vs;
         s2_blank_b <= s1_blank_b;
         s2_show    <= s1_show;
      end
   end

   // Single write port shared by the clear sweep and the pixel write interface.
   // NOTE: every output of this block is given a default first, so no latch can be inferred.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = wr_addr;
      mem_wdata = wr.wr_data;
      if (clr_we) begin
         mem_we    = reset_b;
         mem_waddr = clr_addr;
         mem_wdata = '0;
      end else if (wr_acc && wr_in_range) begin
         mem_we = 1'b1;
      end
   end

   // Framebuffer write port.
   // NOTE: the RAM array has no reset so it maps onto block RAM; the clear sweep initialises it.
   always_ff @(posedge vgaclk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   // Registered read port; a same-edge write to this address is not seen (old data returned).
   always_ff @(posedge vgaclk) begin
      ram_q <= mem[s1_addr];
   end

   // Sticky out-of-range write flag, cleared only by reset.
   always_ff @(posedge vgaclk) begin
      if (!reset_b)                     wr_err <= 1'b0;
      else if (wr_acc && !wr_in_range) wr_err <= 1'b1;
   end

   assign hsync_o   = s2_hs;
   assign vsync_o   = s2_vs;
   assign blank_b_o = s2_blank_b;
   assign r = s2_show ? {ram_q[7:5], ram_q[7:5], ram_q[7:6]} : 8'd0;
   assign g = s2_show ? {ram_q[4:2], ram_q[4:2], ram_q[4:3]} : 8'd0;
   assign b = s2_show ? {4{ram_q[1:0]}} : 8'd0;

`ifdef VGA_PIXEL_PIPE_FB_CLEAR_EN
   typedef enum logic {ST_CLEAR, ST_RUN} state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] clr_addr_nxt;

   // State register and clear sweep address.
   always_ff @(posedge vgaclk) begin
      if (!reset_b) begin
         state    <= ST_CLEAR;
         clr_addr <= '0;
      end else begin
         state    <= state_nxt;
         clr_addr <= clr_addr_nxt;
      end
   end

   // Next state: sweep zeros across the framebuffer, accept writes only in RUN.
   always_comb begin
      state_nxt    = state;
      clr_addr_nxt = clr_addr;
      ready        = 1'b0;
      clr_we       = 1'b0;
      case (state)
         ST_CLEAR: begin
            clr_we = 1'b1;
            if (clear) begin
               clr_addr_nxt = '0;
            end else if (clr_addr == AW'(DEPTH - 1)) begin
               state_nxt    = ST_RUN;
               clr_addr_nxt = '0;
            end else begin
               clr_addr_nxt = clr_addr + 1'b1;
            end
         end
         ST_RUN: begin
            ready = ~clear;
            if (clear) begin
               state_nxt    = ST_CLEAR;
               clr_addr_nxt = '0;
            end
         end
      endcase
   end

   assign in_clear = (state == ST_CLEAR);
`else
   logic run_q;
   logic unused_clear;

   // Writes open on the first edge after reset is released.
   always_ff @(posedge vgaclk) begin
      if (!reset_b) run_q <= 1'b0;
      else          run_q <= 1'b1;
   end

   assign ready        = run_q;
   assign in_clear     = 1'b0;
   assign clr_we       = 1'b0;
   assign clr_addr     = '0;
   assign unused_clear = clear;
`endif

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// tb_vga_pixel_pipe: random raster/write stimulus against a framebuffer-array reference model.
module tb_vga_pixel_pipe;
   localparam int FBW   = 160;
   localparam int FBH   = 120;
   localparam int DEPTH = FBW * FBH;
`ifdef VGA_PIXEL_PIPE_FB_CLEAR_EN
   localparam bit CLR_EN = 1'b1;
`else
   localparam bit CLR_EN = 1'b0;
`endif

   logic       vgaclk = 1'b0;
   logic       reset_b, hsync_i, vsync_i, blank_b_i, clear;
   logic [9:0] x, y;
   logic       hsync_o, vsync_o, blank_b_o, wr_err;
   logic [7:0] r, g, b;

   vga_pixel_pipe_if wr_bus ();

   vga_pixel_pipe #(.FBW(FBW), .FBH(FBH), .SHIFT(2), .XW(10), .YW(10)) dut (
      .vgaclk(vgaclk), .reset_b(reset_b), .x(x), .y(y),
      .hsync_i(hsync_i), .vsync_i(vsync_i), .blank_b_i(blank_b_i), .clear(clear),
      .wr(wr_bus),
      .hsync_o(hsync_o), .vsync_o(vsync_o), .blank_b_o(blank_b_o),
      .r(r), .g(g), .b(b), .wr_err(wr_err)
   );

   always #5 vgaclk = ~vgaclk;

   typedef struct {
      bit rst; bit clr; bit wv;
      logic [7:0] wx; logic [6:0] wy; logic [7:0] wd;
      bit bb; bit hs; bit vs;
      logic [9:0] xx; logic [9:0] yy;
   } stim_t;
   typedef struct { bit valid; bit hs; bit vs; bit bb; bit show; int px; int py; } pend_t;
   typedef struct { bit valid; bit hs; bit vs; bit bb; bit rgb_known; logic [23:0] rgb; } exp_t;

   int         n_vec = 0;
   int         n_bad = 0;
   logic [7:0] fb    [FBH][FBW];
   bit         known [FBH][FBW];
   int         clr_left    = 0;
   bit         rdy_m       = 1'b0;
   bit         err_m       = 1'b0;
   bit         model_valid = 1'b0;
   bit         last_acc    = 1'b0;
   pend_t      pend;
   exp_t       cur;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
      end
   endtask

   // Colour expansion by arithmetic: 3-bit c -> c*36 + c/2, 2-bit c -> c*85.
   function automatic logic [23:0] expand(input logic [7:0] p);
      int rr = int'(p) / 32;
      int gg = (int'(p) / 4) % 8;
      int bl = int'(p) % 4;
      return {8'(rr * 36 + rr / 2), 8'(gg * 36 + gg / 2), 8'(bl * 85)};
   endfunction

   function automatic stim_t rand_stim(input bit local_bias);
      stim_t s;
      s.rst = 1'b0; s.clr = 1'b0; s.wv = 1'b0; s.wx = '0; s.wy = '0; s.wd = '0;
      s.hs = 1'($urandom_range(0, 1));
      s.vs = 1'($urandom_range(0, 1));
      s.bb = ($urandom_range(0, 7) != 0);
      if (s.bb && local_bias && ($urandom_range(0, 1) == 1)) begin
         s.xx = 10'($urandom_range(0, 63));
         s.yy = 10'($urandom_range(0, 63));
      end else if (s.bb) begin
         s.xx = 10'($urandom_range(0, 639));
         s.yy = 10'($urandom_range(0, 479));
      end else begin
         s.xx = 10'($urandom);
         s.yy = 10'($urandom);
      end
      return s;
   endfunction

   task automatic wipe_model();
      for (int i = 0; i < FBH; i++)
         for (int j = 0; j < FBW; j++) begin
            fb[i][j]    = 8'd0;
            known[i][j] = 1'b1;
         end
   endtask

   // One clock: check what the last edge produced, drive this cycle, advance the model to the next edge.
   task automatic run_cycle(input stim_t s);
      exp_t  nxt;
      pend_t np;
      bit    want_rdy, acc;
      @(negedge vgaclk);
      if (cur.valid) begin
         check("hsync_o", 32'(hsync_o), 32'(cur.hs));
         check("vsync_o", 32'(vsync_o), 32'(cur.vs));
         check("blank_b_o", 32'(blank_b_o), 32'(cur.bb));
         if (cur.rgb_known) check("rgb", 32'({r, g, b}), 32'(cur.rgb));
      end
      if (model_valid) check("wr_err", 32'(wr_err), 32'(err_m));
      reset_b = ~s.rst; clear = s.clr;
      wr_bus.wr_valid = s.wv; wr_bus.wr_x = s.wx; wr_bus.wr_y = s.wy; wr_bus.wr_data = s.wd;
      hsync_i = s.hs; vsync_i = s.vs; blank_b_i = s.bb; x = s.xx; y = s.yy;
      #1;
      // Previous cycle's read sees every write up to (not including) the coming edge.
      nxt.valid = pend.valid; nxt.hs = pend.hs; nxt.vs = pend.vs; nxt.bb = pend.bb;
      nxt.rgb_known = 1'b1; nxt.rgb = '0;
      if (pend.valid && pend.show) begin
         nxt.rgb_known = known[pend.py][pend.px];
         nxt.rgb       = expand(fb[pend.py][pend.px]);
      end
      np.valid = 1'b1; np.hs = s.hs; np.vs = s.vs; np.bb = s.bb;
      np.show  = s.bb && (clr_left == 0);
      np.px    = int'(s.xx) / 4;
      np.py    = int'(s.yy) / 4;
      want_rdy = rdy_m && !(CLR_EN && s.clr);
      acc      = 1'b0;
      if (s.rst) begin
         np.hs = 1'b1; np.vs = 1'b1; np.bb = 1'b0; np.show = 1'b0;
         nxt.valid = 1'b1; nxt.hs = 1'b1; nxt.vs = 1'b1; nxt.bb = 1'b0;
         nxt.rgb_known = 1'b1; nxt.rgb = '0;
         clr_left = CLR_EN ? DEPTH : 0;
         rdy_m = 1'b0; err_m = 1'b0; model_valid = 1'b1;
      end else begin
         if (model_valid) check("wr_ready", 32'(wr_bus.wr_ready), 32'(want_rdy));
         acc = s.wv && want_rdy;
         if (acc && int'(s.wx) < FBW && int'(s.wy) < FBH) begin
            fb[s.wy][s.wx]    = s.wd;
            known[s.wy][s.wx] = 1'b1;
         end else if (acc) begin
            err_m = 1'b1;
         end
         if (clr_left > 0) begin
            clr_left--;
            if (CLR_EN && s.clr) clr_left = DEPTH;
            else if (clr_left == 0) wipe_model();
         end else if (CLR_EN && s.clr) begin
            clr_left = DEPTH;
         end
         rdy_m = (clr_left == 0);
      end
      last_acc = acc;
      pend     = np;
      cur      = nxt;
   endtask

   task automatic do_write(input int wx, input int wy, input logic [7:0] wd);
      stim_t s;
      int    tries = 0;
      do begin
         s = rand_stim(1'b1);
         s.wv = 1'b1; s.wx = 8'(wx); s.wy = 7'(wy); s.wd = wd;
         run_cycle(s);
         tries++;
      end while (!last_acc && tries < 25000);
      check("write_accepted", 32'(last_acc), 32'd1);
   endtask

   task automatic read_px(input int xx, input int yy, input bit bb);
      stim_t s;
      s = rand_stim(1'b0);
      s.bb = bb; s.xx = 10'(xx); s.yy = 10'(yy);
      run_cycle(s);
   endtask

   task automatic random_cycles(input int n, input bit with_clear);
      stim_t s;
      for (int i = 0; i < n; i++) begin
         s = rand_stim(1'b1);
         s.wv = 1'($urandom_range(0, 1));
         s.wx = 8'($urandom_range(0, 15));
         s.wy = 7'($urandom_range(0, 15));
         s.wd = 8'($urandom);
         if ($urandom_range(0, 31) == 0) s.wx = 8'($urandom_range(160, 255));
         if (with_clear) s.clr = ($urandom_range(0, 15) == 0);
         run_cycle(s);
      end
   endtask

   task automatic run_until_ready();
      while (clr_left > 0) random_cycles(1, 1'b0);
   endtask

   initial begin
      stim_t s;
      pend.valid = 1'b0;
      cur.valid  = 1'b0;

      // Reset with a write presented: it must be dropped.
      for (int i = 0; i < 3; i++) begin
         s = rand_stim(1'b0);
         s.rst = 1'b1; s.wv = 1'b1; s.wx = 8'd1; s.wy = 7'd1; s.wd = 8'h55;
         run_cycle(s);
      end

`ifdef VGA_PIXEL_PIPE_FB_CLEAR_EN
      // Power-up clear: wr_ready low for the whole sweep, then everything reads 0.
      run_until_ready();
`else
      // Power-up contents are undefined, so paint every pixel first.
      for (int py = 0; py < FBH; py++)
         for (int px = 0; px < FBW; px++)
            do_write(px, py, 8'($urandom));
`endif

      // Single red pixel at (3,2) covers raster x 12..15, y 8..11; x=16 is its neighbour.
      do_write(3, 2, 8'hE0);
      for (int yy = 8; yy < 12; yy++)
         for (int xx = 12; xx <= 16; xx++) read_px(xx, yy, 1'b1);
      read_px(12, 8, 1'b0);
      read_px(13, 9, 1'b1);

      // Out-of-range write: consumed, no pixel changes, sticky error.
      do_write(160, 0, 8'h77);
      read_px(0, 0, 1'b1);
      read_px(0, 4, 1'b1);
      read_px(0, 0, 1'b1);

      random_cycles(4000, 1'b0);

`ifdef VGA_PIXEL_PIPE_FB_CLEAR_EN
      // Paint a block with 8'hFF, then clear with a write presented in the same cycle.
      for (int py = 0; py < 16; py++)
         for (int px = 0; px < 16; px++) do_write(px, py, 8'hFF);
      s = rand_stim(1'b1);
      s.clr = 1'b1; s.wv = 1'b1; s.wx = 8'd5; s.wy = 7'd5; s.wd = 8'hAB;
      run_cycle(s);
      run_until_ready();
      random_cycles(300, 1'b0);

      // Clear restarted by a second pulse, then reset mid-sweep restarts it again.
      s = rand_stim(1'b1); s.clr = 1'b1; run_cycle(s);
      random_cycles(1500, 1'b0);
      s = rand_stim(1'b1); s.clr = 1'b1; run_cycle(s);
      random_cycles(1500, 1'b0);
      s = rand_stim(1'b1); s.rst = 1'b1; run_cycle(s);
      run_until_ready();
      random_cycles(200, 1'b0);
`else
      // Clear pulses are ignored; reset leaves contents and reopens writes a cycle later.
      random_cycles(1000, 1'b1);
      s = rand_stim(1'b1); s.rst = 1'b1; run_cycle(s);
      random_cycles(300, 1'b1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/vga_pixel_pipe.md
# vga_pixel_pipe

Framebuffer-backed pixel stage directly downstream of the VGA timing controller. It takes the controller's raster position, sync and blank signals and holds a 160x120, 8-bit-per-pixel framebuffer, scaled 4x to the 640x480 active area. It emits 24-bit RGB to the DAC with sync and blank re-aligned to the read latency. A valid/ready write port lets upstream logic (SPI receiver, drawing engine) update pixels while the display runs.

## Interface
- FBW, 160: framebuffer width in pixels
- FBH, 120: framebuffer height in pixels
- SHIFT, 2: log2 of the display scale factor; x and y are right-shifted by SHIFT
- XW, 10: width of raster x input
- YW, 10: width of raster y input
- vgaclk  input  1  pixel clock; the only clock
- reset_b  input  1  synchronous, active-low reset
- x  input  XW  raster column from the timing controller
- y  input  YW  raster line from the timing controller
- hsync_i, vsync_i, blank_b_i  input  1 each  controller sync and blank, active low
- wr_valid  input  1  write request
- wr_ready  output  1  write accepted when high with wr_valid
- wr_x  input  8  framebuffer column
- wr_y  input  7  framebuffer row
- wr_data  input  8  pixel, RRRGGGBB
- clear  input  1  one-cycle pulse; re-clears the framebuffer
- hsync_o, vsync_o, blank_b_o  output  1 each  sync and blank delayed to match the RGB outputs
- r, g, b  output  8 each  pixel colour, forced to 0 when blank_b_o is low
- wr_err  output  1  sticky flag for an out-of-range write

## Operation
- Read address = (y >> SHIFT) * FBW + (x >> SHIFT), computed at 15 bits, unsigned.
- When blank_b_i is low, the read address is don't-care and the output colour is 0.
- Colour expansion by bit replication:
  - r = {R,R,R[2:1]}
  - g = {G,G,G[2:1]}
  - b = {B,B,B,B}
- Framebuffer is a simple dual-port RAM: one write port, one registered read port. A read and a write to the same address in the same cycle returns the old data.
- Writes:
  - A handshake (wr_valid & wr_ready) with wr_x < FBW and wr_y < FBH writes wr_data at wr_y*FBW + wr_x.
  - An out-of-range write is consumed without writing and sets wr_err. wr_err clears only on reset.
- State machine:
  - CLEAR: writes 0 to address clr_addr and increments it each cycle. wr_ready = 0. r/g/b are forced to 0 while syncs keep running.
  - CLEAR to RUN: when clr_addr == FBW*FBH-1, the last write is done and the next state is RUN.
  - RUN: wr_ready = 1.
  - RUN to CLEAR: a clear pulse in RUN enters CLEAR with clr_addr = 0. A write presented in the same cycle as clear is not accepted (wr_ready already 0 that cycle, combinationally from clear).
  - clear asserted while already in CLEAR restarts clr_addr at 0.
- Reset (reset_b low at a vgaclk edge):
  - State → CLEAR, clr_addr → 0.
  - Outputs: r/g/b = 0, hsync_o = 1, vsync_o = 1, blank_b_o = 0, wr_ready = 0, wr_err = 0.
  - All pipeline registers are flushed to these idle values.
  - Reset mid-clear or mid-write restarts the clear. A write being accepted on the reset edge is discarded.

## Timing
- Read latency is 2 vgaclk cycles: stage 1 registers the address, stage 2 registers the RAM output and expands the colour.
- hsync_o, vsync_o and blank_b_o pass through a matching 2-stage delay. r/g/b, hsync_o, vsync_o and blank_b_o for raster position (x,y) all appear together, 2 cycles after x,y.
- A write accepted at edge N is visible to a read address registered at edge N+1 or later.
- A full clear takes FBW*FBH = 19200 cycles. wr_ready rises on the cycle after the final clear write.
- The clear runs independently of raster position, so it may span frames.

## Configuration
- VGA_PIXEL_PIPE_FB_CLEAR_EN
  - Defined: CLEAR state, clr_addr counter and the clear input behave as above.
  - Undefined: the state machine is removed, reset goes straight to RUN, and wr_ready = 1 from the first cycle after reset deasserts. The clear input is ignored, framebuffer contents after power-up are undefined, and r/g/b are never force-blanked except by blank_b_o.

## Test plan
- Reset then idle, macro defined → wr_ready stays 0 for 19200 cycles then goes 1. All pixels read 0 during the first frame after clear completes.
- Write wr_x=3, wr_y=2, wr_data=8'hE0 → r=8'hFF, g=0, b=0 exactly 2 cycles after x in 12..15 and y in 8..11, in every active frame; pixel at x=16 reads 0.
- Drive hsync_i/vsync_i/blank_b_i from the timing controller → outputs equal the inputs delayed exactly 2 cycles. r/g/b = 0 whenever blank_b_o = 0, even over a written pixel.
- Write wr_x=160, wr_y=0 → handshake completes, no pixel changes, wr_err = 1 and stays 1 until reset_b is pulsed low.
- Fill the framebuffer with 8'hFF, pulse clear with wr_valid high → that write is not accepted. wr_ready = 0 for 19200 cycles; afterwards every pixel reads 0.
- Assert reset_b low for one cycle midway through a clear → outputs take their reset values on the next edge and the clear restarts, so wr_ready returns after a further 19200 cycles.
